pixel_adc_readout: RTL and testbench

Digital back end for the 2-row pixel array, driven by the phase signals `erase`, `expose`, `convert`, `read1` and `read2` from the pixel state machine.
- During `convert` it runs a single-slope ADC: it drives a ramp code to the shared DAC and latches a per-pixel code when each pixel comparator trips.
- During `read1` and `read2` it streams the latched row codes to the downstream frame buffer over a valid/ready handshake.

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/pixel_adc_readout_if.sv | 40 ++++
 rtl/pixel_ramp_latch.sv | 47 ++++
 rtl/pixel_adc_readout.sv | 146 ++++++++++++++
 tb/tb_pixel_adc_readout.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel ADC read-out slice.
//   - Default array geometry (N_COL_DEF) and ADC code width (DATA_W_DEF).
//   - FULL_SCALE: the code given to a pixel that never trips at the default width.
//   - phase_e: phase state of the read-out back end.
//   - Helpers that decode the phase inputs and the state.
package pixel_pkg;

    localparam int N_COL_DEF  = 2;
    localparam int DATA_W_DEF = 8;
    localparam int unsigned FULL_SCALE = (1 << DATA_W_DEF) - 1;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ1,
        READ2
    } phase_e;

    // Phase vector ordering is {erase, expose, convert, read1, read2}.
    function automatic logic is_multi_hot(input logic [4:0] phase);
        return $countones(phase) > 1;
    endfunction

    function automatic logic is_read(input phase_e s);
        return (s == READ1) || (s == READ2);
    endfunction

endpackage

// File: rtl/pixel_adc_readout_if.sv
// Pixel stream from the read-out back end to the frame buffer.
//   pix_data   : code of the current pixel
//   pix_idx    : flat index (row*N_COL + col) of the current pixel
//   pix_valid  : pix_data/pix_idx are valid
//   pix_ready  : sink accepts the current pixel
//   pix_parity : XOR of pix_data, present only with PIXEL_READOUT_PARITY_EN defined
// master = pixel source (pixel_adc_readout), slave = frame buffer.
interface pixel_adc_readout_if
    import pixel_pkg::*;
#(
    parameter int N_COL  = N_COL_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int IDX_W = $clog2(2 * N_COL);

    logic [DATA_W-1:0] pix_data;
    logic [IDX_W-1:0]  pix_idx;
    logic              pix_valid;
    logic              pix_ready;
`ifdef PIXEL_READOUT_PARITY_EN
    logic              pix_parity;
`endif

    modport master (
        output pix_data, pix_idx, pix_valid,
`ifdef PIXEL_READOUT_PARITY_EN
        output pix_parity,
`endif
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_idx, pix_valid,
`ifdef PIXEL_READOUT_PARITY_EN
        input  pix_parity,
`endif
        output pix_ready
    );

endinterface

// File: rtl/pixel_ramp_latch.sv
// Per-pixel single-slope capture cell: code latch plus "tripped" flag.
//   clk, reset  : clock, synchronous active-high reset
//   clear_all   : clear latch and tripped flag (erase)
//   clear_trip  : clear tripped flag only (start of conversion)
//   capture_en  : conversion cycle; first cmp=1 latches code and sets tripped
//   fill_en     : end of conversion; an un-tripped latch takes full scale
//   cmp         : this pixel's comparator output
//   code        : current ramp code
//   latch_q     : latched pixel code
module pixel_ramp_latch
    import pixel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_all,
    input  logic              clear_trip,
    input  logic              capture_en,
    input  logic              fill_en,
    input  logic              cmp,
    input  logic [DATA_W-1:0] code,
    output logic [DATA_W-1:0] latch_q
);

    logic tripped_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: the code latch is an individual flop per pixel and is reset;
    // read-out after reset must return 0, so it is never left as an
    // unreset storage array.
    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            latch_q   <= '0;
            tripped_q <= 1'b0;
        end else if (clear_trip) begin
            tripped_q <= 1'b0;
        end else if (capture_en && cmp && !tripped_q) begin
            latch_q   <= code;
            tripped_q <= 1'b1;
        end else if (fill_en && !tripped_q) begin
            latch_q   <= '1;
        end
    end

endmodule

// File: rtl/pixel_adc_readout.sv
// Digital back end of the 2 x N_COL pixel array.
//   clk, reset                               : clock, synchronous active-high reset
//   erase, expose, convert, read1, read2     : phase inputs (one-hot or all zero)
//   cmp[2*N_COL]                             : comparators, bit r*N_COL+c = row r col c
//   ramp_code                                : code to the ramp DAC
//   overrun                                  : sticky, read phase left with pixels pending
//   protocol_err                             : sticky, multi-hot phase input seen
//   pix (pixel_adc_readout_if.master)        : pixel stream to the frame buffer
// Optional feature: PIXEL_READOUT_PARITY_EN adds pix.pix_parity = ^pix_data.
module pixel_adc_readout
    import pixel_pkg::*;
#(
    parameter int N_COL  = N_COL_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 erase,
    input  logic                 expose,
    input  logic                 convert,
    input  logic                 read1,
    input  logic                 read2,
    input  logic [2*N_COL-1:0]   cmp,
    output logic [DATA_W-1:0]    ramp_code,
    output logic                 overrun,
    output logic                 protocol_err,
    pixel_adc_readout_if.master  pix
);

    localparam int NPIX  = 2 * N_COL;
    localparam int IDX_W = $clog2(NPIX);

    logic [4:0]        phase_in;
    logic              multi;
    phase_e            state_q, state_d;
    logic              erase_now, conv_enter, conv_stay, conv_exit, capture_en;
    logic              read_enter, read_stay, read_leave;
    logic [IDX_W-1:0]  base_d, last_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic [DATA_W-1:0] ramp_q;
    logic [DATA_W-1:0] lat [NPIX];

    assign phase_in = {erase, expose, convert, read1, read2};
    assign multi    = is_multi_hot(phase_in);

    // The state register is the single registration stage of the phase inputs.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block is given a value before any
        // branch, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        if (!multi) begin
            case (phase_in)
                5'b00000: state_d = IDLE;
                5'b10000: state_d = ERASE;
                5'b01000: state_d = EXPOSE;
                5'b00100: state_d = CONVERT;
                5'b00010: state_d = READ1;
                5'b00001: state_d = READ2;
                default:  state_d = state_q;
            endcase
        end
        // A multi-hot input forces state_d == state_q, so every entry/exit
        // strobe below is already quiet in that cycle.
        erase_now  = !multi && (state_d == ERASE);
        conv_enter = (state_d == CONVERT) && (state_q != CONVERT);
        conv_stay  = !multi && (state_q == CONVERT) && (state_d == CONVERT);
        conv_exit  = (state_q == CONVERT) && (state_d != CONVERT);
        capture_en = !multi && (state_q == CONVERT);
        read_enter = is_read(state_d) && (state_d != state_q);
        read_stay  = is_read(state_q) && (state_d == state_q);
        read_leave = is_read(state_q) && (state_d != state_q);
        base_d     = (state_d == READ2) ? IDX_W'(N_COL) : '0;
        last_q     = (state_q == READ2) ? IDX_W'(NPIX - 1) : IDX_W'(N_COL - 1);
    end

    for (genvar i = 0; i < NPIX; i++) begin : g_pix
        pixel_ramp_latch #(.DATA_W(DATA_W)) u_latch (
            .clk        (clk),
            .reset      (reset),
            .clear_all  (erase_now),
            .clear_trip (conv_enter),
            .capture_en (capture_en),
            .fill_en    (conv_exit),
            .cmp        (cmp[i]),
            .code       (ramp_q),
            .latch_q    (lat[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_q       <= '0;
            overrun      <= 1'b0;
            protocol_err <= 1'b0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            if (multi) protocol_err <= 1'b1;

            // Pixels still pending when the read phase ends are dropped.
            if (read_leave && valid_q && !(pix.pix_ready && idx_q == last_q))
                overrun <= 1'b1;

            // Erase placed after the overrun set so it wins on the same edge.
            if (erase_now) begin
                ramp_q       <= '0;
                overrun      <= 1'b0;
                protocol_err <= 1'b0;
            end else if (conv_enter) begin
                ramp_q <= '0;
            end else if (conv_stay && ramp_q != '1) begin
                ramp_q <= ramp_q + 1'b1;
            end

            if (read_enter) begin
                idx_q   <= base_d;
                valid_q <= 1'b1;
            end else if (read_stay) begin
                if (valid_q && pix.pix_ready) begin
                    if (idx_q == last_q) valid_q <= 1'b0;
                    else                 idx_q   <= idx_q + 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // Latches are static outside CONVERT/ERASE, so the muxed code is stable
    // while a pixel waits for ready and also reflects a capture or fill made
    // on the very edge a read phase begins.
    assign ramp_code     = ramp_q;
    assign pix.pix_valid = valid_q;
    assign pix.pix_idx   = idx_q;
    assign pix.pix_data  = lat[idx_q];
`ifdef PIXEL_READOUT_PARITY_EN
    assign pix.pix_parity = ^lat[idx_q];
`endif

endmodule

// File: tb/tb_pixel_adc_readout.sv
// Self-checking bench for pixel_adc_readout. Inputs are driven and outputs
// sampled on the falling clock edge. The reference model keeps per-pixel
// expected codes (first comparator cycle below the conversion length, else
// full scale), the expected ramp value, and the sticky flags.
module tb_pixel_adc_readout;
    import pixel_pkg::*;

    localparam int N    = N_COL_DEF;
    localparam int DW   = DATA_W_DEF;
    localparam int NPIX = 2 * N;
    localparam int NEVER = 100000;

    localparam bit [4:0] P_IDLE    = 5'b00000;
    localparam bit [4:0] P_ERASE   = 5'b10000;
    localparam bit [4:0] P_EXPOSE  = 5'b01000;
    localparam bit [4:0] P_CONVERT = 5'b00100;
    localparam bit [4:0] P_READ1   = 5'b00010;
    localparam bit [4:0] P_READ2   = 5'b00001;

    logic            clk = 1'b0;
    logic            reset;
    logic            erase, expose, convert, read1, read2;
    logic [NPIX-1:0] cmp;
    logic [DW-1:0]   ramp_code;
    logic            overrun, protocol_err;

    pixel_adc_readout_if #(.N_COL(N), .DATA_W(DW)) pix ();

    pixel_adc_readout #(.N_COL(N), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .erase        (erase),
        .expose       (expose),
        .convert      (convert),
        .read1        (read1),
        .read2        (read2),
        .cmp          (cmp),
        .ramp_code    (ramp_code),
        .overrun      (overrun),
        .protocol_err (protocol_err),
        .pix          (pix)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mdl_lat [NPIX];
    int mdl_ramp;
    bit mdl_overrun;
    bit mdl_perr;
    int t1 [NPIX];
    int t2 [NPIX];
    int xfers;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_phase(input bit [4:0] p);
        {erase, expose, convert, read1, read2} = p;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ramp"}, 32'(ramp_code), 32'(mdl_ramp));
        check({tag, "_overrun"}, 32'(overrun), 32'(mdl_overrun));
        check({tag, "_perr"}, 32'(protocol_err), 32'(mdl_perr));
    endtask

    task automatic do_erase(input int n);
        set_phase(P_ERASE);
        repeat (n) tick();
        for (int i = 0; i < NPIX; i++) mdl_lat[i] = 0;
        mdl_ramp    = 0;
        mdl_overrun = 0;
        mdl_perr    = 0;
        check_status("erase");
        check("erase_valid", 32'(pix.pix_valid), 32'd0);
    endtask

    // Convert for len cycles; pixel i pulses cmp in cycles a[i] and b[i].
    task automatic run_convert(input int len, input int a [NPIX], input int b [NPIX]);
        int first;
        set_phase(P_CONVERT);
        cmp = '0;
        for (int n = 0; n < len; n++) begin
            tick();
            check("conv_ramp", 32'(ramp_code), 32'((n > 255) ? 255 : n));
            check("conv_valid", 32'(pix.pix_valid), 32'd0);
            for (int i = 0; i < NPIX; i++) cmp[i] = (n == a[i]) || (n == b[i]);
        end
        mdl_ramp = (len - 1 > 255) ? 255 : len - 1;
        for (int i = 0; i < NPIX; i++) begin
            first = NEVER;
            if (a[i] < len) first = a[i];
            if (b[i] < len && b[i] < first) first = b[i];
            mdl_lat[i] = (first == NEVER) ? int'(FULL_SCALE) : ((first > 255) ? 255 : first);
        end
    endtask

    // Read one row for ncyc cycles with pix_ready taken from rdy[cycle].
    task automatic run_read(input int row, input int ncyc, input bit [15:0] rdy, output int nx);
        int k;
        int exp_d;
        logic [DW-1:0] exp_b;
        k  = 0;
        nx = 0;
        set_phase(row == 0 ? P_READ1 : P_READ2);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            check("rd_valid", 32'(pix.pix_valid), 32'(k < N));
            if (k < N) begin
                exp_d = mdl_lat[row * N + k];
                exp_b = exp_d[DW-1:0];
                check("rd_idx", 32'(pix.pix_idx), 32'(row * N + k));
                check("rd_data", 32'(pix.pix_data), 32'(exp_d));
`ifdef PIXEL_READOUT_PARITY_EN
                check("rd_parity", 32'(pix.pix_parity), 32'(^exp_b));
`endif
            end
            pix.pix_ready = rdy[c];
            if (pix.pix_valid === 1'b1 && rdy[c]) nx++;
            if (k < N && rdy[c]) k++;
        end
        if (k < N) mdl_overrun = 1;
        check("rd_xfers", 32'(nx), 32'(k));
    endtask

    task automatic do_idle(input int n);
        set_phase(P_IDLE);
        tick();
        pix.pix_ready = 1'b0;
        check("idle_valid", 32'(pix.pix_valid), 32'd0);
        check_status("idle");
        repeat (n - 1) tick();
    endtask

    initial begin
        reset = 1'b1;
        set_phase(P_IDLE);
        cmp = '0;
        pix.pix_ready = 1'b0;
        tick();
        tick();
        // Reset values.
        check("rst_ramp", 32'(ramp_code), 32'd0);
        check("rst_data", 32'(pix.pix_data), 32'd0);
        check("rst_idx", 32'(pix.pix_idx), 32'd0);
        check("rst_valid", 32'(pix.pix_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_perr", 32'(protocol_err), 32'd0);
`ifdef PIXEL_READOUT_PARITY_EN
        check("rst_parity", 32'(pix.pix_parity), 32'd0);
`endif
        reset = 1'b0;
        mdl_ramp = 0; mdl_overrun = 0; mdl_perr = 0;
        for (int i = 0; i < NPIX; i++) mdl_lat[i] = 0;

        // Full frame: trips at codes 5, 17, 200 and never; back-to-back reads.
        do_erase(2);
        t1 = '{5, 17, 200, NEVER};
        t2 = '{NEVER, NEVER, NEVER, NEVER};
        run_convert(300, t1, t2);
        run_read(0, 2, 16'h0003, xfers);
        run_read(1, 2, 16'h0003, xfers);
        do_idle(2);

        // Backpressure: ready 0,0,1,0,1 gives exactly two transfers.
        run_read(0, 5, 16'b10100, xfers);
        check("bp_xfers", 32'(xfers), 32'd2);
        do_idle(1);

        // Short read: two cycles, never ready, then overrun until erase.
        run_read(1, 2, 16'h0000, xfers);
        check("short_xfers", 32'(xfers), 32'd0);
        do_idle(2);
        do_erase(1);

        // Saturation and double trip on pixel 0.
        t1 = '{10, 300, 254, NEVER};
        t2 = '{40, 260, 3, NEVER};
        run_convert(400, t1, t2);
        set_phase(P_EXPOSE);
        tick();
        check_status("sat_expose");
        run_read(0, 2, 16'h0003, xfers);
        run_read(1, 2, 16'h0003, xfers);
        do_idle(1);

        // Protocol error: expose+convert for one cycle while exposing.
        set_phase(P_EXPOSE);
        tick();
        tick();
        set_phase(P_EXPOSE | P_CONVERT);
        tick();
        mdl_perr = 1;
        set_phase(P_EXPOSE);
        tick();
        check_status("perr");
        tick();
        check_status("perr_hold");
        do_erase(1);

        // Randomized frames.
        for (int f = 0; f < 5; f++) begin
            int len;
            do_erase(2);
            len = int'($urandom_range(30, 350));
            for (int i = 0; i < NPIX; i++) begin
                t1[i] = int'($urandom_range(0, 400));
                t2[i] = int'($urandom_range(0, 400));
            end
            run_convert(len, t1, t2);
            if (f[0]) begin
                set_phase(P_EXPOSE);
                tick();
            end
            run_read(0, int'($urandom_range(2, 6)), 16'($urandom), xfers);
            run_read(1, int'($urandom_range(2, 6)), 16'($urandom), xfers);
            do_idle(1);
            run_read(0, 3, 16'hffff, xfers);
            do_idle(1);
        end

        // Reset in the middle of a conversion at code 50.
        set_phase(P_CONVERT);
        cmp = '0;
        for (int n = 0; n <= 50; n++) tick();
        check("abort_ramp50", 32'(ramp_code), 32'd50);
        reset = 1'b1;
        set_phase(P_IDLE);
        tick();
        reset = 1'b0;
        check("abort_ramp", 32'(ramp_code), 32'd0);
        check("abort_valid", 32'(pix.pix_valid), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_data", 32'(pix.pix_data), 32'd0);
        mdl_ramp = 0; mdl_overrun = 0; mdl_perr = 0;
        for (int i = 0; i < NPIX; i++) mdl_lat[i] = 0;
        run_read(0, 2, 16'h0003, xfers);
        run_read(1, 2, 16'h0003, xfers);
        do_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
